// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci partial-sum engine interface.
//   FIB_NTH_W : default width of the index / nth bus
//   FIB_RES_W : default width of the engine result
//   state_t   : sweep master FSM encoding (one-hot, 5 bits)
package fib_pkg;

    localparam int FIB_NTH_W = 8;
    localparam int FIB_RES_W = 20;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ISSUE = 5'b00010,
        S_WAIT  = 5'b00100,
        S_PUSH  = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

endpackage

// File: rtl/fib_sweep_master.sv
// Requesting end of the Fibonacci partial-sum engine. Sweeps nth over
// [first_n..last_n], issues one engine request per index, captures each
// result and streams (index, sum) pairs downstream over valid/ready.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   go, first_n, last_n sweep request (sampled only while idle)
//   busy, done, err     status: busy outside IDLE, done pulse, sticky error
//   fib_start, fib_nth  request to the engine
//   fib_result,
//   fib_out_en          engine response (result valid level)
//   res_valid, res_ready,
//   res_index, res_data downstream result stream
module fib_sweep_master
    import fib_pkg::*;
#(
    parameter int NTH_W   = FIB_NTH_W,
    parameter int RES_W   = FIB_RES_W,
    parameter int TO_W    = 12,
    parameter int TIMEOUT = 4000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [NTH_W-1:0] first_n,
    input  logic [NTH_W-1:0] last_n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             fib_start,
    output logic [NTH_W-1:0] fib_nth,
    input  logic [RES_W-1:0] fib_result,
    input  logic             fib_out_en,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [NTH_W-1:0] res_index,
    output logic [RES_W-1:0] res_data
);

    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [NTH_W-1:0] N_ONE   = {{(NTH_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]  T_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [NTH_W-1:0] cur_n;
    logic [NTH_W-1:0] last_q;
    logic [TO_W-1:0]  timer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cur_n     <= '0;
            last_q    <= '0;
            timer     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            fib_start <= 1'b0;
            fib_nth   <= '0;
            res_valid <= 1'b0;
            res_index <= '0;
            res_data  <= '0;
        end else begin
            // Pulse outputs default low; each state raises them for one cycle.
            done      <= 1'b0;
            fib_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    fib_nth <= '0;
                    if (go) begin
                        if (first_n != '0 && first_n <= last_n) begin
                            cur_n     <= first_n;
                            last_q    <= last_n;
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            // Start is registered on entry so it is high
                            // exactly for the single ISSUE cycle.
                            fib_start <= 1'b1;
                            fib_nth   <= first_n;
                            state     <= S_ISSUE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // out_en is still high from the previous request during
                    // ISSUE; the engine drops it before WAIT, so no stale capture.
                    if (fib_out_en) begin
                        res_data  <= fib_result;
                        res_index <= cur_n;
                        res_valid <= 1'b1;
                        state     <= S_PUSH;
                    end else if (timer == TO_LAST) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        fib_nth <= '0;
                        state   <= S_IDLE;
                    end else begin
                        timer <= timer + T_ONE;
                    end
                end
                S_PUSH: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        // Compare before incrementing so last_n = max never wraps.
                        if (cur_n == last_q) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cur_n     <= cur_n + N_ONE;
                            fib_nth   <= cur_n + N_ONE;
                            fib_start <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    fib_nth <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    fib_nth <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_sweep_master.sv
module tb_fib_sweep_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [7:0]  first_n, last_n;
    logic        busy, done, err;
    logic        fib_start;
    logic [7:0]  fib_nth;
    logic [19:0] fib_result;
    logic        fib_out_en;
    logic        res_valid, res_ready;
    logic [7:0]  res_index;
    logic [19:0] res_data;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    logic stub = 1'b0;

    logic [31:0] exp_idx_q[$];
    logic [31:0] exp_dat_q[$];

    always #5 clk = ~clk;

    fib_sweep_master #(.NTH_W(8), .RES_W(20), .TO_W(12), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .go(go), .first_n(first_n), .last_n(last_n),
        .busy(busy), .done(done), .err(err), .fib_start(fib_start), .fib_nth(fib_nth),
        .fib_result(fib_result), .fib_out_en(fib_out_en), .res_valid(res_valid),
        .res_ready(res_ready), .res_index(res_index), .res_data(res_data)
    );

    // Sum of F(1..n), truncated to 20 bits like the engine.
    function automatic logic [19:0] fibsum(input int n);
        logic [19:0] a, b, s, t;
        a = 20'd0; b = 20'd1; s = 20'd0;
        for (int i = 1; i <= n; i++) begin
            s = s + b;
            t = a + b;
            a = b;
            b = t;
        end
        return s;
    endfunction

    // Behavioural engine: drops out_en the cycle after start, raises it
    // 1..4 cycles later (nth=1 -> out_en two cycles after start), holds it.
    logic [19:0] eng_res;
    logic        eng_en;
    logic [2:0]  eng_cd;
    always_ff @(posedge clk) begin
        if (reset) begin
            eng_en  <= 1'b0;
            eng_cd  <= 3'd0;
            eng_res <= 20'd0;
        end else if (fib_start) begin
            eng_en  <= 1'b0;
            eng_res <= fibsum(int'(fib_nth));
            eng_cd  <= 3'(((int'(fib_nth) - 1) % 4) + 1);
        end else if (eng_cd != 3'd0) begin
            eng_cd <= eng_cd - 3'd1;
            if (eng_cd == 3'd1) eng_en <= 1'b1;
        end
    end
    assign fib_out_en = eng_en & ~stub;
    assign fib_result = eng_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: counts pulses and scores every accepted result.
    always @(negedge clk) begin
        if (!reset) begin
            if (fib_start) start_cnt++;
            if (done) done_cnt++;
            if (res_valid && res_ready) begin
                if (exp_idx_q.size() == 0) begin
                    chk("unexpected_result", 32'(res_index), 32'hFFFF_FFFF);
                end else begin
                    chk("stream_index", 32'(res_index), exp_idx_q.pop_front());
                    chk("stream_data", 32'(res_data), exp_dat_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_pair(input int idx, input int dat);
        exp_idx_q.push_back(32'(idx));
        exp_dat_q.push_back(32'(dat));
    endtask

    task automatic go_pulse(input logic [7:0] f, input logic [7:0] l);
        first_n = f;
        last_n  = l;
        go      = 1'b1;
        step();
        go      = 1'b0;
        first_n = 8'd77;
        last_n  = 8'd3;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        if (busy) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; first_n = 8'd0; last_n = 8'd0; res_ready = 1'b1;
        repeat (3) step();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_valid", 32'(res_valid), 0);
        chk("reset_nth", 32'(fib_nth), 0);
        reset = 1'b0;
        step();

        // Range errors.
        start_cnt = 0;
        go_pulse(8'd0, 8'd5);
        chk("zero_first_err", 32'(err), 1);
        chk("zero_first_busy", 32'(busy), 0);
        step();
        go_pulse(8'd6, 8'd5);
        chk("inverted_err", 32'(err), 1);
        chk("inverted_busy", 32'(busy), 0);
        step(); step();
        chk("range_err_no_start", 32'(start_cnt), 0);

        // Sweep 1..5 with latency checks; also clears err.
        start_cnt = 0; done_cnt = 0;
        expect_pair(1, 1); expect_pair(2, 2); expect_pair(3, 4);
        expect_pair(4, 7); expect_pair(5, 12);
        go_pulse(8'd1, 8'd5);
        chk("lat_start_c1", 32'(fib_start), 1);
        chk("lat_nth_c1", 32'(fib_nth), 1);
        chk("go_clears_err", 32'(err), 0);
        step(); step();
        chk("lat_valid_c3", 32'(res_valid), 0);
        step();
        chk("lat_valid_c4", 32'(res_valid), 1);
        wait_idle("sweep15", 200);
        chk("sweep15_done", 32'(done_cnt), 1);
        chk("sweep15_starts", 32'(start_cnt), 5);
        chk("sweep15_err", 32'(err), 0);

        // Single index 10.
        start_cnt = 0; done_cnt = 0;
        expect_pair(10, 143);
        go_pulse(8'd10, 8'd10);
        wait_idle("single10", 200);
        chk("single10_starts", 32'(start_cnt), 1);
        chk("single10_done", 32'(done_cnt), 1);

        // Backpressure on (3,4).
        start_cnt = 0; done_cnt = 0;
        expect_pair(1, 1); expect_pair(2, 2); expect_pair(3, 4);
        expect_pair(4, 7); expect_pair(5, 12);
        go_pulse(8'd1, 8'd5);
        begin
            int n;
            n = 0;
            while (!(res_valid && res_index == 8'd3) && n < 200) begin
                step();
                n++;
            end
            chk("stall_reached", 32'(res_index), 3);
        end
        res_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_valid", 32'(res_valid), 1);
            chk("stall_index", 32'(res_index), 3);
            chk("stall_data", 32'(res_data), 4);
        end
        chk("stall_starts", 32'(start_cnt), 3);
        res_ready = 1'b1;
        wait_idle("stall", 200);
        chk("stall_done", 32'(done_cnt), 1);
        chk("stall_total_starts", 32'(start_cnt), 5);

        // Timeout with a silent engine.
        start_cnt = 0; done_cnt = 0;
        stub = 1'b1;
        go_pulse(8'd4, 8'd6);
        chk("to_start", 32'(fib_start), 1);
        repeat (16) step();
        chk("to_err_early", 32'(err), 0);
        chk("to_busy_early", 32'(busy), 1);
        step();
        chk("to_err", 32'(err), 1);
        chk("to_busy", 32'(busy), 0);
        step(); step();
        chk("to_no_done", 32'(done_cnt), 0);
        chk("to_starts", 32'(start_cnt), 1);

        // Reset mid-WAIT, then a 255..255 sweep.
        go_pulse(8'd10, 8'd10);
        step(); step(); step();
        reset = 1'b1;
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_start", 32'(fib_start), 0);
        chk("rst_nth", 32'(fib_nth), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_index", 32'(res_index), 0);
        chk("rst_data", 32'(res_data), 0);
        reset = 1'b0;
        stub = 1'b0;
        step();
        start_cnt = 0; done_cnt = 0;
        expect_pair(255, int'(fibsum(255)));
        go_pulse(8'd255, 8'd255);
        wait_idle("n255", 200);
        step(); step(); step();
        chk("n255_starts", 32'(start_cnt), 1);
        chk("n255_done", 32'(done_cnt), 1);
        chk("n255_busy", 32'(busy), 0);

        chk("queue_drained", 32'(exp_idx_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
